// File: rtl/dual_port_instr_mem.sv
// Instruction memory responder shared by two instruction-fetch requesters.
// One word-wide ROM array with a single read port, round-robin arbitration
// between the two ports, and a fixed grant-to-rvalid latency per port.
module dual_port_instr_mem #(
  parameter int    MEM_LOG_SIZE = 10,
  parameter int    LATENCY      = 2,
  parameter string INIT_FILE    = ""
) (
  input  logic        clk,
  input  logic        res,
  input  logic        instr_req_0,
  input  logic [31:0] instr_adr_0,
  output logic        instr_gnt_0,
  output logic        instr_rvalid_0,
  output logic [31:0] instr_read_0,
  input  logic        instr_req_1,
  input  logic [31:0] instr_adr_1,
  output logic        instr_gnt_1,
  output logic        instr_rvalid_1,
  output logic [31:0] instr_read_1
);

  localparam int         DEPTH = 2 ** MEM_LOG_SIZE;
  localparam logic [3:0] LAT_C = 4'(LATENCY);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  logic [31:0] mem [DEPTH];

  // The counter holds the number of edges left before the rvalid flop is
  // loaded, so a BUSY port with counter 1 raises rvalid in the next cycle.
  state_e      state_r      [2];
  state_e      next_state_s [2];
  logic [3:0]  cnt_r        [2];
  logic [3:0]  next_cnt_s   [2];
  logic [31:0] data_r       [2];
  logic [31:0] fire_data_s  [2];
  logic [31:0] read_r       [2];
  logic [1:0]  rvalid_r;
  logic [1:0]  fire_s;
  logic [1:0]  req_s;
  logic [1:0]  elig_s;
  logic [1:0]  gnt_s;
  logic        ptr_r;

  logic [MEM_LOG_SIZE-1:0] idx_0_s;
  logic [MEM_LOG_SIZE-1:0] idx_1_s;
  logic [MEM_LOG_SIZE-1:0] rd_idx_s;
  logic [31:0]             rd_data_s;
  logic                    unused_adr_s;

  // Array contents start unknown until written by the environment.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = {32{1'bx}};
  end

  // Upper address bits alias onto the array; byte offset is ignored.
  assign idx_0_s      = instr_adr_0[MEM_LOG_SIZE+1:2];
  assign idx_1_s      = instr_adr_1[MEM_LOG_SIZE+1:2];
  assign unused_adr_s = ^{instr_adr_0[31:MEM_LOG_SIZE+2], instr_adr_0[1:0],
                          instr_adr_1[31:MEM_LOG_SIZE+2], instr_adr_1[1:0]};
  assign req_s        = {instr_req_1, instr_req_0};

  // Arbiter: at most one grant per cycle; pointer breaks ties; none in reset.
  always_comb begin
    elig_s = 2'b00;
    gnt_s  = 2'b00;
    for (int p = 0; p < 2; p++) begin
      elig_s[p] = req_s[p] && (state_r[p] == ST_IDLE);
    end
    if (!res) begin
      gnt_s = 2'b00;
    end else if (elig_s == 2'b11) begin
      gnt_s = ptr_r ? 2'b10 : 2'b01;
    end else begin
      gnt_s = elig_s;
    end
  end

  // The single array read port follows the granted port's address.
  assign rd_idx_s  = gnt_s[1] ? idx_1_s : idx_0_s;
  assign rd_data_s = mem[rd_idx_s];

  // Per-port next state, counter and rvalid-load decision.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      next_state_s[p] = state_r[p];
      next_cnt_s[p]   = cnt_r[p];
      fire_s[p]       = 1'b0;
      fire_data_s[p]  = data_r[p];
      case (state_r[p])
        ST_IDLE: begin
          if (gnt_s[p]) begin
            if (LAT_C == 4'd1) begin
              fire_s[p]      = 1'b1;
              fire_data_s[p] = rd_data_s;
            end else begin
              next_state_s[p] = ST_BUSY;
              next_cnt_s[p]   = LAT_C - 4'd1;
            end
          end else begin
            next_state_s[p] = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (cnt_r[p] == 4'd1) begin
            fire_s[p]       = 1'b1;
            next_state_s[p] = ST_IDLE;
            next_cnt_s[p]   = 4'd0;
          end else begin
            next_cnt_s[p] = cnt_r[p] - 4'd1;
          end
        end
        default: begin
          next_state_s[p] = ST_IDLE;
          next_cnt_s[p]   = 4'd0;
        end
      endcase
    end
  end

  // State, captured data, output flops and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!res) begin
      ptr_r    <= 1'b0;
      rvalid_r <= 2'b00;
      for (int p = 0; p < 2; p++) begin
        state_r[p] <= ST_IDLE;
        cnt_r[p]   <= 4'd0;
        data_r[p]  <= 32'h0000_0000;
        read_r[p]  <= 32'h0000_0000;
      end
    end else begin
      if (gnt_s != 2'b00) begin
        ptr_r <= gnt_s[0];
      end
      rvalid_r <= fire_s;
      for (int p = 0; p < 2; p++) begin
        state_r[p] <= next_state_s[p];
        cnt_r[p]   <= next_cnt_s[p];
        read_r[p]  <= fire_s[p] ? fire_data_s[p] : 32'h0000_0000;
        if (gnt_s[p]) begin
          data_r[p] <= rd_data_s;
        end
      end
    end
  end

  assign instr_gnt_0    = gnt_s[0];
  assign instr_gnt_1    = gnt_s[1];
  assign instr_rvalid_0 = rvalid_r[0];
  assign instr_rvalid_1 = rvalid_r[1];
  assign instr_read_0   = read_r[0];
  assign instr_read_1   = read_r[1];

endmodule

// File: tb/tb_dual_port_instr_mem.sv
// Bench for dual_port_instr_mem: directed scenarios followed by random
// traffic, checked every cycle against a timestamp-based reference model.
module tb_dual_port_instr_mem;

  localparam int MLS   = 10;
  localparam int LAT   = 2;
  localparam int DEPTH = 2 ** MLS;

  logic        clk = 1'b0;
  logic        res;
  logic        req_0, req_1;
  logic [31:0] adr_0, adr_1;
  logic        gnt_0, gnt_1, rvalid_0, rvalid_1;
  logic [31:0] read_0, read_1;

  dual_port_instr_mem #(.MEM_LOG_SIZE(MLS), .LATENCY(LAT), .INIT_FILE("")) dut (
    .clk(clk), .res(res),
    .instr_req_0(req_0), .instr_adr_0(adr_0), .instr_gnt_0(gnt_0),
    .instr_rvalid_0(rvalid_0), .instr_read_0(read_0),
    .instr_req_1(req_1), .instr_adr_1(adr_1), .instr_gnt_1(gnt_1),
    .instr_rvalid_1(rvalid_1), .instr_read_1(read_1)
  );

  always #5 clk = ~clk;

  // Reference model: each port remembers the cycle its data is due.
  logic [31:0] mem_m [DEPTH];
  bit          pend_m [2];
  int          due_m  [2];
  logic [31:0] dat_m  [2];
  bit          gnt_m  [2];
  bit          ptr_m;
  int          cyc;
  bit          checking;
  int          total, passed, fails;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already driven; check, then advance model.
  task automatic cycle();
    bit          rq [2];
    logic [31:0] ad [2];
    bit          rv [2];
    bit          el [2];
    rq[0] = req_0; rq[1] = req_1;
    ad[0] = adr_0; ad[1] = adr_1;
    #1;
    for (int p = 0; p < 2; p++) begin
      rv[p] = pend_m[p] && (due_m[p] == cyc);
      el[p] = rq[p] && (!pend_m[p] || rv[p]);
      gnt_m[p] = 1'b0;
    end
    if (res) begin
      if (el[0] && el[1]) begin
        gnt_m[0] = (ptr_m == 1'b0);
        gnt_m[1] = (ptr_m == 1'b1);
      end else begin
        gnt_m[0] = el[0];
        gnt_m[1] = el[1];
      end
    end
    if (checking) begin
      check("gnt_0", {31'd0, gnt_0}, {31'd0, gnt_m[0]});
      check("gnt_1", {31'd0, gnt_1}, {31'd0, gnt_m[1]});
      check("rvalid_0", {31'd0, rvalid_0}, {31'd0, rv[0]});
      check("rvalid_1", {31'd0, rvalid_1}, {31'd0, rv[1]});
      check("read_0", read_0, rv[0] ? dat_m[0] : 32'h0);
      check("read_1", read_1, rv[1] ? dat_m[1] : 32'h0);
    end
    @(posedge clk);
    if (!res) begin
      pend_m[0] = 1'b0;
      pend_m[1] = 1'b0;
      ptr_m     = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (rv[p]) pend_m[p] = 1'b0;
        if (gnt_m[p]) begin
          pend_m[p] = 1'b1;
          due_m[p]  = cyc + LAT;
          dat_m[p]  = mem_m[ad[p][MLS+1:2]];
        end
      end
      if (gnt_m[0] || gnt_m[1]) ptr_m = gnt_m[0];
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic [31:0] v;
    total = 0; passed = 0; fails = 0; cyc = 0; checking = 1'b0;
    ptr_m = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pend_m[p] = 1'b0; due_m[p] = 0; dat_m[p] = 32'h0; gnt_m[p] = 1'b0;
    end
    res = 1'b0; req_0 = 1'b1; req_1 = 1'b1; adr_0 = 32'h0; adr_1 = 32'h4;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      if (i == 5) v = 32'hDEADBEEF;
      mem_m[i]   = v;
      dut.mem[i] = v;
    end
    @(negedge clk);
    cycle();                   // first edge settles unknown power-up state
    checking = 1'b1;

    // Reset held with both requests up: nothing granted or returned.
    idle(3);

    // Single read of word 5.
    res = 1'b1; req_1 = 1'b0; req_0 = 1'b1; adr_0 = 32'h14;
    cycle();
    req_0 = 1'b0; adr_0 = 32'h0;
    idle(3);

    // Contention after reset, then busy-port re-request held high.
    res = 1'b0; cycle(); res = 1'b1;
    req_0 = 1'b1; adr_0 = 32'h20; req_1 = 1'b1; adr_1 = 32'h30;
    cycle();
    cycle();
    req_1 = 1'b0;
    cycle();
    req_0 = 1'b0;
    idle(4);

    // Aliased address, changed right after the grant.
    req_0 = 1'b1; adr_0 = 32'h0000_1014;
    cycle();
    req_0 = 1'b0; adr_0 = 32'h0000_0008;
    idle(3);

    // Reset in the middle of a read, then a fresh tie.
    req_0 = 1'b1; adr_0 = 32'h14;
    cycle();
    req_0 = 1'b0; res = 1'b0;
    cycle();
    res = 1'b1;
    idle(3);
    req_0 = 1'b1; adr_0 = 32'h40; req_1 = 1'b1; adr_1 = 32'h0000_2014;
    cycle();
    cycle();
    req_0 = 1'b0; req_1 = 1'b0;
    idle(4);

    // Random traffic; an ungranted request is held with its address.
    for (int n = 0; n < 400; n++) begin
      if (!(req_0 && !gnt_m[0])) begin
        req_0 = ($urandom_range(0, 3) != 0);
        adr_0 = $urandom;
      end
      if (!(req_1 && !gnt_m[1])) begin
        req_1 = ($urandom_range(0, 3) != 0);
        adr_1 = $urandom;
      end
      res = ($urandom_range(0, 59) != 0);
      cycle();
    end
    res = 1'b1; req_0 = 1'b0; req_1 = 1'b0;
    idle(4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
